// File: rtl/input_debouncer.sv
// input_debouncer
// Synchronises a vector of raw, asynchronous pins with a two-flop
// synchroniser, then filters each bit with its own stability counter.
// A bit's debounced level only moves once the synchronised input has
// disagreed with it for STABLE_COUNT consecutive clocks. One-cycle
// rise/fall pulses and an aggregate 'changed' pulse accompany each flip.
// Every output is a flop; nothing from 'in' reaches an output
// combinationally.
module input_debouncer #(
  parameter int               WIDTH        = 32,
  parameter int               COUNT_BITS   = 16,
  parameter int               STABLE_COUNT = 50000,
  parameter logic [WIDTH-1:0] RESET_PAT    = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // ------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ------------------------------------------------------------------
  if (WIDTH < 1) begin : g_bad_width
    $error("input_debouncer: WIDTH must be at least 1");
  end

  if (COUNT_BITS < 1) begin : g_bad_count_bits
    $error("input_debouncer: COUNT_BITS must be at least 1");
  end

  // The counter must be able to hold STABLE_COUNT-1 without wrapping.
  if ((STABLE_COUNT < 1) ||
      (64'(STABLE_COUNT) >= (64'd1 << COUNT_BITS))) begin : g_bad_stable_count
    $error("input_debouncer: STABLE_COUNT must satisfy 1 <= STABLE_COUNT < 2**COUNT_BITS");
  end

  // ------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------
  // Counter value at which the next mismatching edge accepts the new level.
  localparam logic [COUNT_BITS-1:0] LAST_CNT = COUNT_BITS'(STABLE_COUNT - 1);
  localparam logic [COUNT_BITS-1:0] CNT_ZERO = {COUNT_BITS{1'b0}};
  localparam logic [COUNT_BITS-1:0] CNT_ONE  = COUNT_BITS'(1);
  localparam logic [WIDTH-1:0]      VEC_ZERO = {WIDTH{1'b0}};

  // ------------------------------------------------------------------
  // State and next-state signals
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]      sync1_r;
  logic [WIDTH-1:0]      sync2_r;
  logic [COUNT_BITS-1:0] cnt_r      [WIDTH];

  logic [COUNT_BITS-1:0] cnt_nxt_s  [WIDTH];
  logic [WIDTH-1:0]      out_nxt_s;
  logic [WIDTH-1:0]      rise_nxt_s;
  logic [WIDTH-1:0]      fall_nxt_s;
  logic                  changed_nxt_s;

  // ------------------------------------------------------------------
  // Synchroniser
  // ------------------------------------------------------------------
  // Two-flop synchroniser bringing the asynchronous pins into clk_i.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      sync1_r <= RESET_PAT;
      sync2_r <= RESET_PAT;
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
    end
  end

  // ------------------------------------------------------------------
  // Per-bit stability filter
  // ------------------------------------------------------------------
  // Next-state for each bit: clear on agreement, count on disagreement,
  // and accept the synchronised level when the run reaches STABLE_COUNT.
  always_comb begin
    out_nxt_s  = out;
    rise_nxt_s = VEC_ZERO;
    fall_nxt_s = VEC_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = CNT_ZERO;
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == out[i]) begin
        // Input agrees with the accepted level: any partial run is a
        // glitch and is forgotten.
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] >= LAST_CNT) begin
        // Final mismatching edge of a full run: take the new level.
        // The >= also pulls an out-of-range count straight back to 0.
        cnt_nxt_s[i]  = CNT_ZERO;
        out_nxt_s[i]  = sync2_r[i];
        rise_nxt_s[i] = sync2_r[i];
        fall_nxt_s[i] = ~sync2_r[i];
      end else begin
        // Run still in progress.
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end

    // Aggregate pulse derived from next-state so it lines up with rise/fall.
    changed_nxt_s = |(rise_nxt_s | fall_nxt_s);
  end

  // ------------------------------------------------------------------
  // Filter registers and pulse outputs
  // ------------------------------------------------------------------
  // Register debounced levels, counters and pulses; reset beats a pending flip.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      out     <= RESET_PAT;
      rise    <= VEC_ZERO;
      fall    <= VEC_ZERO;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      out     <= out_nxt_s;
      rise    <= rise_nxt_s;
      fall    <= fall_nxt_s;
      changed <= changed_nxt_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer.
// Two instances: A (WIDTH=8, STABLE_COUNT=4) for the main scenarios and
// B (WIDTH=8, STABLE_COUNT=1) for the minimum-filter case. Expected
// observations are queued with the edge number at which they are due and
// compared #1 after that edge.
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_a,  out_a, rise_a, fall_a;
  logic       changed_a;
  logic [7:0] in_b,  out_b, rise_b, fall_b;
  logic       changed_b;

  always #5 clk = ~clk;

  input_debouncer #(
    .WIDTH(8), .COUNT_BITS(3), .STABLE_COUNT(4), .RESET_PAT(8'h00)
  ) u_dut_a (
    .clk_i(clk), .reset(reset), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .changed(changed_a)
  );

  input_debouncer #(
    .WIDTH(8), .COUNT_BITS(2), .STABLE_COUNT(1), .RESET_PAT(8'h00)
  ) u_dut_b (
    .clk_i(clk), .reset(reset), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
  );

  typedef struct {
    int          due;
    int          scen;
    bit          sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int edge_n = 0;

  function automatic logic [31:0] pack_obs(input logic [7:0] o, input logic [7:0] r,
                                            input logic [7:0] f, input logic c);
    return {7'd0, o, r, f, c};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got out/rise/fall/chg=%h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int scen, input int ahead, input bit sel, input logic [31:0] exp);
    sb_entry_t e;
    e.due  = edge_n + ahead;
    e.scen = scen;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic expect_quiet(input int scen, input int from, input int to,
                              input bit sel, input logic [7:0] lvl);
    for (int i = from; i <= to; i++) begin
      expect_at(scen, i, sel, pack_obs(lvl, 8'h00, 8'h00, 1'b0));
    end
  endtask

  // Advance one edge, then compare every queued entry due at this edge.
  task automatic tick();
    int          k;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    edge_n++;
    k = 0;
    while (k < sb_q.size()) begin
      if (sb_q[k].due == edge_n) begin
        obs = sb_q[k].sel ? pack_obs(out_b, rise_b, fall_b, changed_b)
                          : pack_obs(out_a, rise_a, fall_a, changed_a);
        check_val($sformatf("s%0d_%s_e%0d", sb_q[k].scen, sb_q[k].sel ? "b" : "a", edge_n),
                  obs, sb_q[k].exp);
        sb_q.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  task automatic drive_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] bounce [6];
    reset = 1'b1;
    in_a  = 8'hFF;
    in_b  = 8'h00;

    // 1: reset held with inputs high, then release.
    expect_at(1, 3, 1'b0, pack_obs(8'h00, 8'h00, 8'h00, 1'b0));
    expect_at(1, 3, 1'b1, pack_obs(8'h00, 8'h00, 8'h00, 1'b0));
    drive_ticks(3);
    reset = 1'b0;
    expect_quiet(1, 1, 5, 1'b0, 8'h00);
    expect_at(1, 6, 1'b0, pack_obs(8'hFF, 8'hFF, 8'h00, 1'b1));
    expect_at(1, 7, 1'b0, pack_obs(8'hFF, 8'h00, 8'h00, 1'b0));
    drive_ticks(7);
    // Return all bits to 0: a full-width fall.
    in_a = 8'h00;
    expect_quiet(1, 1, 5, 1'b0, 8'hFF);
    expect_at(1, 6, 1'b0, pack_obs(8'h00, 8'h00, 8'hFF, 1'b1));
    expect_at(1, 7, 1'b0, pack_obs(8'h00, 8'h00, 8'h00, 1'b0));
    drive_ticks(7);

    // 2: glitch of 3 clocks on in[0] is rejected.
    expect_quiet(2, 1, 10, 1'b0, 8'h00);
    in_a = 8'h01;
    drive_ticks(3);
    in_a = 8'h00;
    drive_ticks(7);

    // 3: bounce on in[3], then hold high.
    bounce[0] = 8'h08; bounce[1] = 8'h00; bounce[2] = 8'h08;
    bounce[3] = 8'h08; bounce[4] = 8'h00; bounce[5] = 8'h08;
    expect_quiet(3, 1, 10, 1'b0, 8'h00);
    expect_at(3, 11, 1'b0, pack_obs(8'h08, 8'h08, 8'h00, 1'b1));
    expect_at(3, 12, 1'b0, pack_obs(8'h08, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 6; i++) begin
      in_a = bounce[i];
      tick();
    end
    in_a = 8'h08;
    drive_ticks(6);

    // 4a: move to out=0x04; bit 3 falls and bit 2 rises together.
    in_a = 8'h04;
    expect_quiet(4, 1, 5, 1'b0, 8'h08);
    expect_at(4, 6, 1'b0, pack_obs(8'h04, 8'h04, 8'h08, 1'b1));
    expect_at(4, 7, 1'b0, pack_obs(8'h04, 8'h00, 8'h00, 1'b0));
    drive_ticks(7);
    // 4b: set in[1], clear in[2] two clocks later.
    expect_quiet(4, 1, 5, 1'b0, 8'h04);
    expect_at(4, 6, 1'b0, pack_obs(8'h06, 8'h02, 8'h00, 1'b1));
    expect_at(4, 7, 1'b0, pack_obs(8'h06, 8'h00, 8'h00, 1'b0));
    expect_at(4, 8, 1'b0, pack_obs(8'h02, 8'h00, 8'h04, 1'b1));
    expect_at(4, 9, 1'b0, pack_obs(8'h02, 8'h00, 8'h00, 1'b0));
    in_a = 8'h06;
    drive_ticks(2);
    in_a = 8'h02;
    drive_ticks(7);

    // 5: back to 0, then reset in the middle of a run on in[5].
    in_a = 8'h00;
    expect_quiet(5, 1, 5, 1'b0, 8'h02);
    expect_at(5, 6, 1'b0, pack_obs(8'h00, 8'h00, 8'h02, 1'b1));
    expect_at(5, 7, 1'b0, pack_obs(8'h00, 8'h00, 8'h00, 1'b0));
    drive_ticks(7);
    expect_quiet(5, 1, 10, 1'b0, 8'h00);
    expect_at(5, 11, 1'b0, pack_obs(8'h20, 8'h20, 8'h00, 1'b1));
    expect_at(5, 12, 1'b0, pack_obs(8'h20, 8'h00, 8'h00, 1'b0));
    in_a = 8'h20;
    drive_ticks(4);       // counter for bit 5 is now 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_ticks(7);

    // 6: minimum filter on instance B, 1-clock pulse on in[7].
    expect_quiet(6, 1, 2, 1'b1, 8'h00);
    expect_at(6, 3, 1'b1, pack_obs(8'h80, 8'h80, 8'h00, 1'b1));
    expect_at(6, 4, 1'b1, pack_obs(8'h00, 8'h00, 8'h80, 1'b1));
    expect_at(6, 5, 1'b1, pack_obs(8'h00, 8'h00, 8'h00, 1'b0));
    in_b = 8'h80;
    tick();
    in_b = 8'h00;
    drive_ticks(4);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
